prim_skid_reg: RTL and testbench
================================

Name: prim_skid_reg

Overview:
- Valid/ready pipeline register stage with a one-entry skid buffer. It is the handshaking counterpart to a plain flop stage.
- It registers both the forward path (valid/data) and the backward path (ready), so no combinational path exists between the ports.
- Sustains one transfer per cycle.
- Placed between a producer and a consumer to break long timing paths on bus and stream interfaces.

Parameters:
- Width, 32, data path width in bits.
- ResetValue, '0, value loaded into the output and skid data registers on reset.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock, reset is synchronous and active-high
- flush_i  input  1  synchronous discard of all held entries
- valid_i  input  1  upstream data valid
- ready_o  output  1  upstream ready (registered)
- data_i  input  Width  upstream data
- valid_o  output  1  downstream data valid
- ready_i  input  1  downstream ready
- data_o  output  Width  downstream data (registered)
- depth_o  output  2  entries held: 0, 1 or 2

Behaviour:
- Transfer rules:
  - Upstream transfer when valid_i && ready_o.
  - Downstream transfer when valid_o && ready_i.
  - Both may occur in the same cycle.
- State enum: EMPTY (0 entries), BUSY (output register holds 1 entry), FULL (output register plus skid register hold 2 entries).
- EMPTY: valid_o=0.
  - Upstream transfer: out_q<=data_i, go to BUSY.
  - Otherwise stay.
- BUSY: valid_o=1.
  - In and out together: out_q<=data_i, stay in BUSY.
  - In only: skid_q<=data_i, go to FULL.
  - Out only: go to EMPTY.
  - Neither: hold.
- FULL: valid_o=1 and ready_o=0, so valid_i is ignored.
  - Out: out_q<=skid_q, go to BUSY.
  - Otherwise hold.
- ready_o is a flop with next value (next_state != FULL). It never depends combinationally on ready_i.
- data_o=out_q, valid_o=(state!=EMPTY), depth_o=state encoding 0/1/2.
- Latency: 1 cycle from upstream transfer to valid_o/data_o, when empty. Throughput: 1 transfer per cycle in steady state.
- Ordering: strictly FIFO. The skid entry always drains before any newer data.
- Stability guarantee: while valid_o=1 && ready_i=0, valid_o and data_o hold unchanged.
- Upstream obligation: the producer holds valid_i and data_i until accepted. The block does not depend on this for correctness, because it samples only on transfer.
- Reset, with rst_i high at a clock edge:
  - state=EMPTY, ready_o=0, valid_o=0, depth_o=0.
  - out_q=skid_q=ResetValue.
  - ready_o rises in the first cycle after rst_i deasserts.
  - Reset mid-operation drops all entries.
- flush_i, lower priority than rst_i and higher than any handshake:
  - Next state=EMPTY, ready_o next=1, all entries discarded.
  - A same-cycle upstream transfer is dropped.
  - Data registers are not cleared.
- Simultaneous rst_i and flush_i: reset wins.
- Boundary conditions:
  - FULL with ready_i=0 for many cycles: data held, ready_o stays 0.
  - FULL with ready_i=1 and valid_i=1: the skid entry is delivered next and valid_i is not accepted that cycle.

Decomposition:
- Package prim_skid_pkg holds the state typedef skid_state_e {SkidEmpty=2'd0, SkidBusy=2'd1, SkidFull=2'd2}. depth_o is a direct cast of this state.
- No sub-module. The two data registers and the state/ready flops are inline always_ff blocks with synchronous active-high reset.

Test Plan:
- Reset/idle: hold rst_i for 3 cycles, then release. Required: valid_o=0, depth_o=0 and ready_o=0 during reset; ready_o=1 exactly one cycle after release.
- Streaming: Width=8, ready_i=1, valid_i=1 with data 0x01..0x10 on consecutive cycles. Required: data_o shows 0x01..0x10 one cycle later, no bubbles, depth_o=1 throughout.
- Backpressure fill:
  - Send 0xA1 then 0xA2 with ready_i=0. Required: depth_o goes 1 then 2, ready_o=0, data_o=0xA1 held stable.
  - Then raise ready_i. Required: outputs 0xA1, then 0xA2, then valid_o=0.
- Full plus simultaneous input: in FULL with ready_i=1 and valid_i=1 carrying 0xB3. Required: 0xB3 not accepted that cycle, ready_o returns to 1 next cycle, and 0xB3 is output after the skid entry.
- Flush: in FULL holding 0xC1/0xC2, assert flush_i with valid_i=1 carrying 0xC3. Required: next cycle valid_o=0, depth_o=0, ready_o=1, and 0xC1, 0xC2 and 0xC3 are never output.
- Reset mid-operation: in BUSY holding 0xD1, assert rst_i together with flush_i and valid_i. Required: next cycle valid_o=0, ready_o=0, data_o=ResetValue.

Source files
------------

// File: rtl/prim_skid_pkg.sv
// Shared types for the valid/ready skid register stage.
package prim_skid_pkg;

   // Occupancy state. The encoding is exported directly as the entry count.
   typedef enum logic [1:0] {
      SkidEmpty = 2'd0,
      SkidBusy  = 2'd1,
      SkidFull  = 2'd2
   } skid_state_e;

   localparam int unsigned SkidDepthW = 2;

endpackage

// File: rtl/prim_skid_reg.sv
// Valid/ready register stage with a one-entry skid buffer. Both the forward
// (valid/data) and backward (ready) paths are registered, so no combinational
// path crosses the stage.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SkidEmpty | nothing held, valid_o low
// SkidBusy  | output register holds one entry
// SkidFull  | output and skid registers both hold entries, ready_o low
module prim_skid_reg
   import prim_skid_pkg::*;
#(
   parameter int unsigned           Width      = 32,
   parameter logic [Width-1:0]      ResetValue = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [Width-1:0]      data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [Width-1:0]      data_o,
   output logic [SkidDepthW-1:0] depth_o
);

   skid_state_e      state_q, state_d;
   logic             ready_q;
   logic [Width-1:0] out_q;
   logic [Width-1:0] skid_q;

   logic up_xfer;
   logic down_xfer;
   logic load_out_in;
   logic load_out_skid;
   logic load_skid;

   assign up_xfer   = valid_i && ready_q;
   assign down_xfer = valid_o && ready_i;

   // Next state and register load enables; flush overrides every handshake.
   always_comb begin
      state_d       = state_q;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state_q)
         SkidEmpty: begin
            if (up_xfer) begin
               load_out_in = 1'b1;
               state_d     = SkidBusy;
            end
         end
         SkidBusy: begin
            if (up_xfer && down_xfer) begin
               load_out_in = 1'b1;
            end else if (up_xfer) begin
               load_skid = 1'b1;
               state_d   = SkidFull;
            end else if (down_xfer) begin
               state_d = SkidEmpty;
            end
         end
         SkidFull: begin
            // ready_o is low here, so any valid_i is simply not accepted.
            if (down_xfer) begin
               load_out_skid = 1'b1;
               state_d       = SkidBusy;
            end
         end
         default: state_d = SkidEmpty;
      endcase
      if (flush_i) begin
         state_d       = SkidEmpty;
         load_out_in   = 1'b0;
         load_out_skid = 1'b0;
         load_skid     = 1'b0;
      end
   end

   // State and registered ready; ready_o stays low for the reset cycle itself.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SkidEmpty;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != SkidFull);
      end
   end

   // Output data register: fresh input when passing through, skid when draining.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q <= ResetValue;
      end else if (load_out_in) begin
         out_q <= data_i;
      end else if (load_out_skid) begin
         out_q <= skid_q;
      end
   end

   // Skid data register catches the word accepted while the output stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         skid_q <= ResetValue;
      end else if (load_skid) begin
         skid_q <= data_i;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = (state_q != SkidEmpty);
   assign data_o  = out_q;
   assign depth_o = SkidDepthW'(state_q);

   // A stalled output must not change until it is taken, flushed or reset.
   hold_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));

   // Never accept new data while both registers are occupied.
   no_accept_full_a : assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == SkidFull) |-> !ready_o);

   // Only the three legal occupancy encodings are ever reached.
   legal_state_a : assert property (@(posedge clk_i)
      (state_q != 2'd3));

endmodule

// File: tb/tb_prim_skid_reg.sv
// Self-checking bench for prim_skid_reg: directed scenarios plus a random run,
// all compared against a queue-based occupancy model.
module tb_prim_skid_reg;
   import prim_skid_pkg::*;

   localparam int unsigned    W   = 8;
   localparam logic [W-1:0]   RV  = 8'h5A;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [W-1:0]  data_i = '0;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic [W-1:0]  data_o;
   logic [1:0]    depth_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: entries currently held, oldest first, and the
   // registered ready flag as seen by the producer.
   logic [W-1:0] mq[$];
   bit           m_ready = 1'b0;

   prim_skid_reg #(.Width(W), .ResetValue(RV)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .depth_o (depth_o)
   );

   always #5 clk_i = ~clk_i;

   // Apply one cycle of inputs, advance the model at the edge, sample after.
   task automatic step(input logic rst, input logic fl, input logic v,
                       input logic r, input logic [W-1:0] d);
      bit up, down;
      rst_i   = rst;
      flush_i = fl;
      valid_i = v;
      ready_i = r;
      data_i  = d;
      @(posedge clk_i);
      if (rst) begin
         mq.delete();
         m_ready = 1'b0;
      end else if (fl) begin
         mq.delete();
         m_ready = 1'b1;
      end else begin
         up   = v && m_ready;
         down = (mq.size() != 0) && r;
         if (down) void'(mq.pop_front());
         if (up) mq.push_back(d);
         m_ready = (mq.size() < 2);
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
         n_vec++;
         if (valid_o !== 1'b0 || depth_o !== 2'd0 || ready_o !== 1'b0 || data_o !== RV) begin
            n_err++;
            $display("FAIL reset_hold cyc=%0d: valid=%b depth=%0d ready=%b data=%h, want 0 0 0 %h",
                     i, valid_o, depth_o, ready_o, data_o, RV);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_vec++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b valid=%b, want ready=1 valid=0", ready_o, valid_o);
      end
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, W'(i));
         n_vec++;
         if (valid_o !== 1'b1 || data_o !== W'(i) || depth_o !== 2'd1 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL stream[%0d]: valid=%b data=%h depth=%0d ready=%b, want 1 %h 1 1",
                     i, valid_o, data_o, depth_o, ready_o, W'(i));
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++;
      if (valid_o !== 1'b0 || depth_o !== 2'd0) begin
         n_err++;
         $display("FAIL stream_drain: valid=%b depth=%0d, want 0 0", valid_o, depth_o);
      end
   endtask

   task automatic test_backpressure();
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hA1);
      n_vec++;
      if (depth_o !== 2'd1 || data_o !== 8'hA1 || ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL bp_first: depth=%0d data=%h ready=%b, want 1 a1 1", depth_o, data_o, ready_o);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hA2);
      n_vec++;
      if (depth_o !== 2'd2 || data_o !== 8'hA1 || ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL bp_full: depth=%0d data=%h ready=%b, want 2 a1 0", depth_o, data_o, ready_o);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
         n_vec++;
         if (depth_o !== 2'd2 || data_o !== 8'hA1 || ready_o !== 1'b0 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: depth=%0d data=%h ready=%b valid=%b, want 2 a1 0 1",
                     i, depth_o, data_o, ready_o, valid_o);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++;
      if (valid_o !== 1'b1 || data_o !== 8'hA2 || depth_o !== 2'd1 || ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL bp_drain1: valid=%b data=%h depth=%0d ready=%b, want 1 a2 1 1",
                  valid_o, data_o, depth_o, ready_o);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++;
      if (valid_o !== 1'b0 || depth_o !== 2'd0) begin
         n_err++;
         $display("FAIL bp_drain2: valid=%b depth=%0d, want 0 0", valid_o, depth_o);
      end
   endtask

   task automatic test_full_plus_input();
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hB1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hB2);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'hB3);
      n_vec++;
      if (data_o !== 8'hB2 || depth_o !== 2'd1 || ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL full_in_skid: data=%h depth=%0d ready=%b, want b2 1 1", data_o, depth_o, ready_o);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'hB3);
      n_vec++;
      if (data_o !== 8'hB3 || depth_o !== 2'd1 || valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL full_in_next: data=%h depth=%0d valid=%b, want b3 1 1", data_o, depth_o, valid_o);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL full_in_drain: valid=%b, want 0", valid_o);
      end
   endtask

   task automatic test_flush();
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hC1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hC2);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3);
      n_vec++;
      if (valid_o !== 1'b0 || depth_o !== 2'd0 || ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL flush: valid=%b depth=%0d ready=%b, want 0 0 1", valid_o, depth_o, ready_o);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
         n_vec++;
         if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after[%0d]: valid=%b data=%h, want valid 0", i, valid_o, data_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'hD1);
      n_vec++;
      if (depth_o !== 2'd1 || data_o !== 8'hD1) begin
         n_err++;
         $display("FAIL rstmid_load: depth=%0d data=%h, want 1 d1", depth_o, data_o);
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'hD4);
      n_vec++;
      if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o !== RV || depth_o !== 2'd0) begin
         n_err++;
         $display("FAIL rstmid: valid=%b ready=%b data=%h depth=%0d, want 0 0 %h 0",
                  valid_o, ready_o, data_o, depth_o, RV);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_vec++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_release: ready=%b valid=%b, want 1 0", ready_o, valid_o);
      end
   endtask

   task automatic test_random();
      logic          r, v, fl, rs;
      logic [W-1:0]  d;
      for (int i = 0; i < 2000; i++) begin
         rs = ($urandom_range(0, 199) == 0);
         fl = ($urandom_range(0, 49) == 0);
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         d  = W'($urandom);
         step(rs, fl, v, r, d);
         n_vec++;
         if (valid_o !== (mq.size() != 0) || depth_o !== 2'(mq.size()) || ready_o !== m_ready) begin
            n_err++;
            $display("FAIL rand[%0d]: valid=%b depth=%0d ready=%b, want %b %0d %b",
                     i, valid_o, depth_o, ready_o, mq.size() != 0, mq.size(), m_ready);
         end
         if (mq.size() != 0) begin
            n_vec++;
            if (data_o !== mq[0]) begin
               n_err++;
               $display("FAIL rand_data[%0d]: data=%h, want %h", i, data_o, mq[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_full_plus_input();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
